fft_pingpong_sched: RTL
=======================

Name: fft_pingpong_sched

Overview:
Frame scheduler for one ping-pong FFT stage buffer (two banks of 2^LOG2N words). It accepts a sample stream over valid/ready and generates the buffer's enable, start, write-enable and write-address controls. It presents the buffer's read stream downstream with valid/ready and frame markers, stalling the buffer on backpressure. It sits between an upstream FFT stage or input formatter and the buffer/butterfly of the next stage.

Parameters:
LOG2N, 8, log2 of frame length; N = 2^LOG2N samples per frame (one buffer bank)
CNTW, 16, width of completed-frame counter

Ports:
clock_c  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
s_valid  in  1  upstream sample valid
s_last  in  1  marks last sample of last frame of a burst; sampled only when cnt==N-1
s_ready  out  1  scheduler accepts a sample this cycle
buf_en  out  1  buffer advance/clock-enable
buf_start  out  1  buffer frame start / bank swap, only with buf_en
buf_we  out  1  buffer write enable
buf_waddr  out  LOG2N  buffer write address
m_valid  out  1  buffer output word valid
m_ready  in  1  downstream accepts word
m_sof  out  1  with m_valid: first word of a frame
m_eof  out  1  with m_valid: last word of a frame
busy  out  1  state!=IDLE or m_valid
frame_cnt  out  CNTW  frames fully read out since reset, wraps modulo 2^CNTW

Behaviour:
- States: IDLE, FILL (first frame, no readout), STREAM (write frame k+1 while reading frame k), FLUSH (read final frame, no writes). One shared counter cnt (LOG2N bits); reads and writes run in lockstep.
- stall = m_valid & ~m_ready. s_ready = ~stall & state in {IDLE,FILL,STREAM}. accept = s_valid & s_ready.
- buf_en = accept | (state==FLUSH & ~stall). buf_we = accept. buf_waddr = cnt.
- buf_start = buf_en & cnt==0 & state in {IDLE,STREAM,FLUSH}. This is a combinational pulse on the advance carrying word 0 of a frame.
- IDLE: on accept, cnt->1, go to FILL.
- FILL: on accept, cnt++. When accept at cnt==N-1: cnt->0; go to FLUSH if s_last, else STREAM.
- STREAM: on accept, cnt++. When accept at cnt==N-1: cnt->0, frame_cnt++; go to FLUSH if s_last, else stay in STREAM.
- FLUSH: on each buf_en, cnt++. When buf_en at cnt==N-1: cnt->0, frame_cnt++, go to IDLE.
- Output flags are registered on buf_en:
  - m_valid <= state in {STREAM,FLUSH}.
  - m_sof <= cnt==0.
  - m_eof <= cnt==N-1.
  - Otherwise m_valid clears when m_ready=1.
  - Words appear one cycle after their advance. Read latency is 1 advance, total frame latency is N accepts.
- During stall, buf_en=0; buffer output, m_valid, m_sof and m_eof hold stable.
- s_last outside cnt==N-1 is ignored.
- Input gaps in STREAM pause reads too, since there is no advance. In FILL/STREAM, m_valid drops after the current word is consumed.
- Reset (any state, mid-frame included): state IDLE, cnt=0, frame_cnt=0, all outputs 0 except s_ready=1 (m_valid=0, so no stall). The partial frame is discarded. The buffer is reset by the same reset.
- cnt wraps naturally at N; no overflow handling needed.

Optional Feature:
FFT_BITREV_EN
- Defined: buf_waddr = bit-reverse(cnt) over LOG2N bits, so natural-order input is stored for bit-reversed readout. The read side is unchanged.
- Undefined: buf_waddr = cnt.

Decomposition:
- Package fft_sched_pkg:
  - state enum {IDLE,FILL,STREAM,FLUSH}
  - default LOG2N/CNTW constants
  - bitrev function
- One sub-module: fft_sched_outreg, the m_valid/m_sof/m_eof register with stall hold.

Test Plan:
- LOG2N=3, s_valid=1 for 16 samples, s_last on sample 16, m_ready=1:
  - buf_start on accepts 0 and 8, then on the first FLUSH advance;
  - m_valid for 16 cycles starting 1 cycle after accept 8;
  - m_sof at outputs 0 and 8, m_eof at 7 and 15;
  - frame_cnt=2, then IDLE, busy=0.
- Same run with m_ready low for 3 cycles mid-STREAM: s_ready=0 and buf_en=0 for 3 cycles; m_valid and data held; no sample lost or duplicated.
- s_valid gapped (1 of every 2 cycles) in STREAM: buf_we and buf_waddr advance only on accepts; m_valid toggles; output order intact.
- s_last asserted at cnt=3: ignored, state stays STREAM.
- reset asserted at cnt=5 in STREAM: next cycle state IDLE, cnt=0, m_valid=0, frame_cnt=0; new frame starts with buf_start on first accept.
- FFT_BITREV_EN defined, LOG2N=3: buf_waddr sequence 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/fft_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fft_sched_pkg
// Purpose : Shared types, default sizes and helpers for the ping-pong FFT
//           stage scheduler (state encoding, default LOG2N/CNTW, bit reversal).
// Revision: 1.0 - initial release
// ============================================================================
package fft_sched_pkg;

    localparam int LOG2N_DEF = 8;
    localparam int CNTW_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } sched_state_t;

    // Reverse the low 'width' bits of 'value'; bits at or above 'width' are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[i] = value[width-1-i];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_pingpong_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : fft_pingpong_sched_if
// Purpose : Sample-in / word-out stream handshake of the FFT frame scheduler.
//   s_valid, s_last, s_ready : upstream sample stream
//   m_valid, m_ready         : downstream word stream
//   m_sof, m_eof             : frame markers qualified by m_valid
//   slave  modport : scheduler side
//   master modport : producer/consumer side (testbench, neighbours)
// Revision: 1.0 - initial release
// ============================================================================
interface fft_pingpong_sched_if;
    logic s_valid;
    logic s_last;
    logic s_ready;
    logic m_valid;
    logic m_ready;
    logic m_sof;
    logic m_eof;

    modport slave (
        input  s_valid, s_last, m_ready,
        output s_ready, m_valid, m_sof, m_eof
    );

    modport master (
        output s_valid, s_last, m_ready,
        input  s_ready, m_valid, m_sof, m_eof
    );
endinterface
`default_nettype wire

// File: rtl/fft_sched_outreg.sv
`default_nettype none
// ============================================================================
// Module  : fft_sched_outreg
// Purpose : Output word flag register (valid / start-of-frame / end-of-frame).
//   Loads on every buffer advance; otherwise valid drops once consumed, and
//   everything holds while the consumer stalls.
//   clock_c, reset : clock, synchronous active-high reset
//   i_adv          : buffer advance this cycle
//   i_rd           : the advance carries a readable word
//   i_sof, i_eof   : word position flags for the advance
//   i_ready        : downstream ready
//   o_valid, o_sof, o_eof : registered flags
// Revision: 1.0 - initial release
// ============================================================================
module fft_sched_outreg (
    input  wire logic clock_c,
    input  wire logic reset,
    input  wire logic i_adv,
    input  wire logic i_rd,
    input  wire logic i_sof,
    input  wire logic i_eof,
    input  wire logic i_ready,
    output logic      o_valid,
    output logic      o_sof,
    output logic      o_eof
);

    logic r_valid;
    logic r_sof;
    logic r_eof;

    always_ff @(posedge clock_c) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
        end else if (i_adv) begin
            r_valid <= i_rd;
            r_sof   <= i_sof;
            r_eof   <= i_eof;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_sof   = r_sof;
    assign o_eof   = r_eof;

endmodule
`default_nettype wire

// File: rtl/fft_pingpong_sched.sv
`default_nettype none
// ============================================================================
// Module  : fft_pingpong_sched
// Purpose : Frame scheduler for one ping-pong FFT stage buffer (two banks of
//           2^LOG2N words). Writes frame k+1 while reading frame k, with one
//           shared word counter for both directions.
//   clock_c, reset : clock, synchronous active-high reset
//   sif (slave)    : s_valid/s_last/s_ready in, m_valid/m_ready/m_sof/m_eof out
//   buf_en         : buffer advance
//   buf_start      : frame start / bank swap (only with buf_en)
//   buf_we         : buffer write enable
//   buf_waddr      : buffer write address
//   busy           : not idle, or a word is still presented
//   frame_cnt      : frames fully read out since reset (wrapping)
// Build option: define FFT_BITREV_EN to store samples at bit-reversed addresses.
// Revision: 1.0 - initial release
// ============================================================================
module fft_pingpong_sched
    import fft_sched_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  wire logic          clock_c,
    input  wire logic          reset,
    fft_pingpong_sched_if.slave sif,
    output logic               buf_en,
    output logic               buf_start,
    output logic               buf_we,
    output logic [LOG2N-1:0]   buf_waddr,
    output logic               busy,
    output logic [CNTW-1:0]    frame_cnt
);

    localparam logic [LOG2N-1:0] C_CNT_LAST = '1;

    sched_state_t     r_state, w_state_nxt;
    logic [LOG2N-1:0] r_cnt, w_cnt_nxt;
    logic [CNTW-1:0]  r_frame_cnt, w_frame_cnt_nxt;

    logic w_m_valid;
    logic w_stall;
    logic w_s_ready;
    logic w_accept;
    logic w_cnt_zero;
    logic w_cnt_last;
    logic w_rd;

    assign w_stall    = w_m_valid & ~sif.m_ready;
    assign w_s_ready  = ~w_stall & (r_state != FLUSH);
    assign w_accept   = sif.s_valid & w_s_ready;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_last = (r_cnt == C_CNT_LAST);
    // Only STREAM and FLUSH advances read a previously written frame.
    assign w_rd       = (r_state == STREAM) | (r_state == FLUSH);

    assign sif.s_ready = w_s_ready;
    assign buf_en      = w_accept | ((r_state == FLUSH) & ~w_stall);
    assign buf_we      = w_accept;
    // FILL never starts a frame: its word 0 was taken in IDLE.
    assign buf_start   = buf_en & w_cnt_zero & (r_state != FILL);
    assign busy        = (r_state != IDLE) | w_m_valid;
    assign frame_cnt   = r_frame_cnt;

`ifdef FFT_BITREV_EN
    assign buf_waddr = LOG2N'(bitrev(32'(r_cnt), LOG2N));
`else
    assign buf_waddr = r_cnt;
`endif

    always_ff @(posedge clock_c) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_frame_cnt_nxt = r_frame_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = LOG2N'(1);
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + LOG2N'(1);
                    if (w_cnt_last) begin
                        w_state_nxt = sif.s_last ? FLUSH : STREAM;
                    end
                end
            end
            STREAM: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + LOG2N'(1);
                    if (w_cnt_last) begin
                        w_frame_cnt_nxt = r_frame_cnt + CNTW'(1);
                        if (sif.s_last) begin
                            w_state_nxt = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (buf_en) begin
                    w_cnt_nxt = r_cnt + LOG2N'(1);
                    if (w_cnt_last) begin
                        w_frame_cnt_nxt = r_frame_cnt + CNTW'(1);
                        w_state_nxt     = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    fft_sched_outreg u_outreg (
        .clock_c (clock_c),
        .reset   (reset),
        .i_adv   (buf_en),
        .i_rd    (w_rd),
        .i_sof   (w_cnt_zero),
        .i_eof   (w_cnt_last),
        .i_ready (sif.m_ready),
        .o_valid (w_m_valid),
        .o_sof   (sif.m_sof),
        .o_eof   (sif.m_eof)
    );

    assign sif.m_valid = w_m_valid;

endmodule
`default_nettype wire
